// File: rtl/i2s_pkg.sv
// Shared constants, the stereo sample type and the slot serialiser bit-select
// for the I2S transmit path.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int SAMPLE_W   = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  // Bit k of a slot: k=0 is the I2S one-bit delay, then MSB first, then zero pad.
  function automatic logic slot_bit(input logic [SLOT_BITS-1:0] word,
                                    input logic [4:0]           k,
                                    input logic [4:0]           width);
    logic [4:0] idx;
    idx = width - k;
    if ((k != 5'd0) && (k <= width)) begin
      slot_bit = word[idx];
    end else begin
      slot_bit = 1'b0;
    end
  endfunction

endpackage

// File: rtl/i2s_if.sv
// Sample handshake plus I2S pin bundle between the audio source and the transmitter.
interface i2s_if #(parameter int SAMPLE_W = i2s_pkg::SAMPLE_W);

  logic signed [SAMPLE_W-1:0] left_sample_in;
  logic signed [SAMPLE_W-1:0] right_sample_in;
  logic                       sample_valid_in;
  logic                       frame_req_out;
  logic                       underrun_out;
  logic                       overrun_out;
  logic                       i2s_bclk_out;
  logic                       i2s_lrclk_out;
  logic                       i2s_data_out;

  modport master (
    output left_sample_in, right_sample_in, sample_valid_in,
    input  frame_req_out, underrun_out, overrun_out,
    input  i2s_bclk_out, i2s_lrclk_out, i2s_data_out
  );

  modport slave (
    input  left_sample_in, right_sample_in, sample_valid_in,
    output frame_req_out, underrun_out, overrun_out,
    output i2s_bclk_out, i2s_lrclk_out, i2s_data_out
  );

endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK divider shared by the I2S transmit and receive paths; the strobes mark
// the system-clock cycle at whose end BCLK toggles.
module i2s_clk_gen #(
  parameter int BCLK_HALF = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       bclk_q, bclk_d;
  logic       wrap_s;

  assign wrap_s = (div_cnt_q == 8'(BCLK_HALF - 1));

  // divider next state
  always_comb begin
    if (wrap_s) begin
      div_cnt_d = 8'd0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
      bclk_d    = bclk_q;
    end
  end

  // divider registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= 8'd0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign rise_stb_o = wrap_s & ~bclk_q;
  assign fall_stb_o = wrap_s &  bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Stereo I2S master transmitter: 64-BCLK frames, left slot then right slot,
// fed from a single holding register with underrun/overrun reporting.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 12,
  parameter int SAMPLE_W  = i2s_pkg::SAMPLE_W
) (
  input  logic  clk_in,
  input  logic  rst_in,
  i2s_if.slave  bus
);

  logic                       rise_stb_s, fall_stb_s, latch_s;
  logic [5:0]                 bit_cnt_q, bit_cnt_d, bit_cnt_inc_s;
  logic                       bclk_q, bclk_d, lrclk_q, lrclk_d, data_q, data_d;
  logic signed [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic signed [SAMPLE_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic [SAMPLE_W-1:0]        slot_s;
  logic                       fresh_q, fresh_d;
  logic                       frame_req_q, frame_req_d;
  logic                       underrun_q, underrun_d, overrun_q, overrun_d;

  i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .rise_stb_o (rise_stb_s),
    .fall_stb_o (fall_stb_s)
  );

  assign latch_s       = fall_stb_s & (bit_cnt_q == 6'(FRAME_BITS - 1));
  assign bit_cnt_inc_s = bit_cnt_q + 6'd1;
  assign slot_s        = bit_cnt_inc_s[5] ? frame_r_q : frame_l_q;

  // serialiser: bit counter, word select and data move on the BCLK falling edge
  always_comb begin
    if (rise_stb_s) begin
      bclk_d = 1'b1;
    end else if (fall_stb_s) begin
      bclk_d = 1'b0;
    end else begin
      bclk_d = bclk_q;
    end
    if (fall_stb_s) begin
      bit_cnt_d = bit_cnt_inc_s;
      lrclk_d   = bit_cnt_inc_s[5];
      data_d    = slot_bit({{(SLOT_BITS - SAMPLE_W){1'b0}}, slot_s},
                           bit_cnt_inc_s[4:0], 5'(SAMPLE_W));
    end else begin
      bit_cnt_d = bit_cnt_q;
      lrclk_d   = lrclk_q;
      data_d    = data_q;
    end
  end

  // holding/frame registers; a latch always consumes the pre-update holding value
  always_comb begin
    if (latch_s) begin
      frame_l_d = hold_l_q;
      frame_r_d = hold_r_q;
    end else begin
      frame_l_d = frame_l_q;
      frame_r_d = frame_r_q;
    end
    if (bus.sample_valid_in) begin
      hold_l_d = bus.left_sample_in;
      hold_r_d = bus.right_sample_in;
      fresh_d  = 1'b1;
    end else if (latch_s) begin
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      fresh_d  = 1'b0;
    end else begin
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      fresh_d  = fresh_q;
    end
    frame_req_d = latch_s;
    underrun_d  = latch_s & ~fresh_q;
    overrun_d   = bus.sample_valid_in & fresh_q & ~latch_s;
  end

  // state and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt_q   <= 6'd63;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b1;
      data_q      <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      fresh_q     <= 1'b0;
      frame_req_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      data_q      <= data_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      fresh_q     <= fresh_d;
      frame_req_q <= frame_req_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.i2s_bclk_out  = bclk_q;
  assign bus.i2s_lrclk_out = lrclk_q;
  assign bus.i2s_data_out  = data_q;
  assign bus.frame_req_out = frame_req_q;
  assign bus.underrun_out  = underrun_q;
  assign bus.overrun_out   = overrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: frames are captured on BCLK rising edges
// and compared with hand-computed slot images and edge times.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  localparam int HALF = 12;

  // expected frame contents, in capture order (last entry is the frame after mid-frame reset)
  localparam logic [15:0] EXP_L  [9] = '{16'h0000, 16'h8001, 16'h1234, 16'h1234, 16'h1234,
                                         16'h5555, 16'hAAAA, 16'h0002, 16'h0000};
  localparam logic [15:0] EXP_R  [9] = '{16'h0000, 16'h7FFE, 16'h4321, 16'h4321, 16'h4321,
                                         16'h0F0F, 16'hF0F0, 16'h2100, 16'h0000};
  localparam logic        EXP_UR [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic        ur;
    logic [63:0] bits;
  } frame_t;

  logic   clk, rst;
  int     cyc;
  int     n_checks, n_errors;
  int     stray_ur;
  frame_t frames_q [$];
  int     bclk_rise_q [$], bclk_fall_q [$], lr_rise_q [$], lr_fall_q [$], ovr_q [$];

  i2s_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  i2s_transmitter #(.BCLK_HALF(HALF), .SAMPLE_W(SAMPLE_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // edges since reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
  endfunction

  task automatic wait_cyc(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  task automatic send_sample(input int at_cyc, input stereo_sample_t s);
    wait_cyc(at_cyc);
    bus.left_sample_in  = s.left;
    bus.right_sample_in = s.right;
    bus.sample_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid_in = 1'b0;
  endtask

  initial begin : monitor
    logic        bclk_p, lr_p, in_frame, cur_ur;
    logic [63:0] bits;
    int          nbits;
    bclk_p = 1'b0; lr_p = 1'b1; in_frame = 1'b0; cur_ur = 1'b0;
    bits = '0; nbits = 0; stray_ur = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        nbits    = 0;
      end else begin
        if (bus.frame_req_out) begin
          in_frame = 1'b1;
          nbits    = 0;
          cur_ur   = bus.underrun_out;
        end else if (bus.underrun_out) begin
          stray_ur++;
        end
        if (bus.overrun_out) ovr_q.push_back(cyc);
        if (bus.i2s_bclk_out && !bclk_p) begin
          bclk_rise_q.push_back(cyc);
          if (in_frame) begin
            bits = {bits[62:0], bus.i2s_data_out};
            nbits++;
            if (nbits == 64) begin
              frames_q.push_back({cur_ur, bits});
              in_frame = 1'b0;
            end
          end
        end
        if (!bus.i2s_bclk_out && bclk_p) bclk_fall_q.push_back(cyc);
        if (bus.i2s_lrclk_out && !lr_p)  lr_rise_q.push_back(cyc);
        if (!bus.i2s_lrclk_out && lr_p)  lr_fall_q.push_back(cyc);
      end
      bclk_p = bus.i2s_bclk_out;
      lr_p   = bus.i2s_lrclk_out;
    end
  end

  initial begin : stim
    rst = 1'b1;
    n_checks = 0;
    n_errors = 0;
    bus.sample_valid_in = 1'b0;
    bus.left_sample_in  = '0;
    bus.right_sample_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bclk",     64'(bus.i2s_bclk_out),  64'd0);
    check_eq("rst_lrclk",    64'(bus.i2s_lrclk_out), 64'd1);
    check_eq("rst_data",     64'(bus.i2s_data_out),  64'd0);
    check_eq("rst_framereq", 64'(bus.frame_req_out), 64'd0);
    check_eq("rst_underrun", 64'(bus.underrun_out),  64'd0);
    check_eq("rst_overrun",  64'(bus.overrun_out),   64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // latches occur at edges 24 + 1536*m
    send_sample(100,  '{left: 16'h8001, right: 16'h7FFE});
    send_sample(1660, '{left: 16'h1234, right: 16'h4321});
    send_sample(6268, '{left: 16'h5555, right: 16'h0F0F});
    send_sample(7703, '{left: 16'hAAAA, right: 16'hF0F0});
    send_sample(9340, '{left: 16'h0001, right: 16'h1000});
    send_sample(9440, '{left: 16'h0002, right: 16'h2100});

    // bit_cnt = 40 of the frame latched at edge 12312: right slot bit 8 of 16'h2100
    wait_cyc(13272);
    check_eq("pre_rst_data", 64'(bus.i2s_data_out), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_bclk",     64'(bus.i2s_bclk_out),  64'd0);
    check_eq("midrst_lrclk",    64'(bus.i2s_lrclk_out), 64'd1);
    check_eq("midrst_data",     64'(bus.i2s_data_out),  64'd0);
    check_eq("midrst_framereq", 64'(bus.frame_req_out), 64'd0);
    rst = 1'b0;
    wait_cyc(1600);

    check_eq("first_bclk_fall", 64'((bclk_fall_q.size() > 0) ? bclk_fall_q[0] : -1), 64'd24);
    check_eq("bclk_period",
             64'((bclk_rise_q.size() > 1) ? (bclk_rise_q[1] - bclk_rise_q[0]) : -1), 64'd24);
    check_eq("lrclk_first_fall", 64'((lr_fall_q.size() > 0) ? lr_fall_q[0] : -1), 64'd24);
    check_eq("lrclk_first_rise", 64'((lr_rise_q.size() > 0) ? lr_rise_q[0] : -1), 64'd792);
    check_eq("lrclk_period",     64'((lr_fall_q.size() > 1) ? lr_fall_q[1] : -1), 64'd1560);

    check_eq("frame_count", 64'(frames_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < frames_q.size()) begin
        check_eq($sformatf("frame%0d_bits", i), frames_q[i].bits, mk_frame(EXP_L[i], EXP_R[i]));
        check_eq($sformatf("frame%0d_underrun", i), 64'(frames_q[i].ur), 64'(EXP_UR[i]));
      end else begin
        check_eq($sformatf("frame%0d_present", i), 64'(frames_q.size()), 64'(i + 1));
      end
    end

    check_eq("overrun_count", 64'(ovr_q.size()), 64'd1);
    check_eq("overrun_cycle", 64'((ovr_q.size() > 0) ? ovr_q[0] : -1), 64'd9441);
    check_eq("stray_underrun", 64'(stray_ur), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S bus master transmitter that drives a stereo 16-bit sample stream to an external I2S DAC/amplifier. It is the outbound counterpart of the existing microphone receive path.
- Generates BCLK and LRCLK from the 100 MHz system clock. Frames are 64 BCLK long: 32-bit left slot, then 32-bit right slot.
- Sits between the FIR/anti-noise output and the I2S speaker pins. It replaces the PWM audio path when an I2S amp is fitted.

Parameters:
- BCLK_HALF, 12, clk_in cycles per BCLK half-period. Default gives BCLK = 4.167 MHz and fs = 65.1 kHz. Legal range 2..255.
- SAMPLE_W, 16, sample width in bits. Must be ≤ 31.

Ports:
- clk_in  input  1  100 MHz system clock. The block uses this single clock only.
- rst_in  input  1  synchronous, active-high reset.
- left_sample_in  input  SAMPLE_W  signed left sample.
- right_sample_in  input  SAMPLE_W  signed right sample.
- sample_valid_in  input  1  one-cycle strobe; captures both samples into the holding register.
- frame_req_out  output  1  one-cycle pulse when the holding register is consumed into a new frame.
- underrun_out  output  1  one-cycle pulse, coincident with frame_req_out, when the consumed holding value was not fresh.
- overrun_out  output  1  one-cycle pulse when sample_valid_in overwrites a fresh, unconsumed holding value.
- i2s_bclk_out  output  1  bit clock.
- i2s_lrclk_out  output  1  word select: 0 = left, 1 = right.
- i2s_data_out  output  1  serial data, MSB first.

Behaviour:
- Reset values while rst_in is high, on every clk_in edge:
  - div_cnt = 0, bclk = 0, bit_cnt = 63, lrclk = 1, data = 0.
  - Holding and frame registers = 0, fresh = 0.
  - All pulse outputs = 0.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1.
  - At BCLK_HALF-1 it wraps and bclk toggles.
  - rise_stb/fall_stb are internal single-cycle strobes asserted in the cycle bclk toggles 0→1 / 1→0.
  - First falling edge occurs 2·BCLK_HALF cycles after reset release. BCLK period is 2·BCLK_HALF cycles.
- All of bit_cnt, lrclk and data update only on fall_stb, so the receiver samples on the BCLK rising edge.
  - bit_cnt increments mod 64.
  - lrclk = 0 for bit_cnt 0..31 and 1 for 32..63.
- Slot data, with k = bit_cnt mod 32 and S = the channel's frame register (left for the first half, right for the second):
  - k = 0: output 0 (the I2S one-bit delay).
  - k = 1..SAMPLE_W: output S[SAMPLE_W-k], i.e. MSB first.
  - k > SAMPLE_W: output 0 (zero pad).
- Frame latch, on the fall_stb where bit_cnt wraps 63→0:
  - The frame registers load from the holding register.
  - frame_req_out pulses in the same cycle.
  - underrun_out pulses if fresh = 0; fresh then clears.
  - On underrun the previous holding value is repeated; it is not zeroed.
- Holding register and fresh flag:
  - sample_valid_in loads holding and sets fresh.
  - If fresh was already 1 and no latch occurs in that cycle, overrun_out pulses. The newest data wins.
- Simultaneous sample_valid_in and frame latch in the same cycle:
  - The latch takes the OLD holding value and underrun is evaluated on the old fresh value.
  - Holding takes the new samples and fresh ends at 1.
  - No overrun is reported.
- Reset mid-frame:
  - Outputs return to reset values on the next edge and the current frame is abandoned.
  - After release, the first frame transmits the zeroed holding register and reports underrun.
- Output latency: the MSB of a sample written before a latch appears on i2s_data_out 2·BCLK_HALF cycles after that latch (bit_cnt = 1).
- Outputs are registered, with no combinational path from the inputs.

Decomposition:
- Package i2s_pkg holds:
  - FRAME_BITS = 64 and SLOT_BITS = 32.
  - SAMPLE_W default.
  - stereo_sample_t struct (signed left, signed right).
- Sub-module i2s_clk_gen holds div_cnt, bclk, rise_stb and fall_stb, parameterised by BCLK_HALF. The receiver is refactored to share it.

Test Plan:
- Timing check:
  - Stimulus: reset, then free-run.
  - Required: BCLK period = 24 cycles; LRCLK period = 1536 cycles with 50% duty; first fall_stb 24 cycles after reset release.
- Bit-pattern check:
  - Stimulus: load L=16'h8001, R=16'h7FFE before a latch.
  - Required: the next frame, captured on BCLK rising edges, is 0,1000…0001, then 15 zeros; then 0,0111…1110, then 15 zeros.
- Underrun repeat:
  - Stimulus: load L=16'h1234 once and give no further valid.
  - Required: the first latch reports no underrun; every subsequent frame repeats 16'h1234 with underrun_out = 1 at each frame_req_out.
- Simultaneous event:
  - Stimulus: assert valid with L=16'hAAAA in the exact fall_stb cycle of the 63→0 wrap, where holding = 16'h5555 and fresh = 1.
  - Required: the current frame carries 16'h5555; no underrun and no overrun; the next frame carries 16'hAAAA with no underrun.
- Overrun:
  - Stimulus: two valids between latches, with L=16'h0001 then 16'h0002.
  - Required: overrun_out pulses on the second valid; the frame carries 16'h0002.
- Reset mid-frame:
  - Stimulus: assert rst_in at bit_cnt = 40 for 1 cycle.
  - Required: next edge gives bclk = 0, lrclk = 1, data = 0; after release the first frame is all zeros and underrun_out = 1.
